// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// The loader is the slave; the stream source / memory side is the master.
interface prog_loader_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             wen;
  logic [WIDTH-1:0] waddr;
  logic [WIDTH-1:0] wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, wen, waddr, wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, wen, waddr, wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time instruction ROM writer: takes a little-endian word count followed by
// that many little-endian words and writes them to consecutive word addresses.
module prog_loader #(
  parameter int WIDTH    = 32,
  parameter int ROMDEPTH = 2048
) (
  input  logic         clock,
  input  logic         reset,
  prog_loader_if.slave bus,
  output logic         core_hold,
  output logic         done,
  output logic         error
);

  localparam int IDXW = $clog2(ROMDEPTH + 1);

  typedef enum logic [2:0] {
    HEADER,
    LOAD,
    FINISH,
    DONE,
    ERROR
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [1:0]         r_byteCnt;
  logic [23:0]        r_asm;
  logic [WIDTH-1:0]   r_n;
  logic [IDXW-1:0]    r_wordIdx;
  logic               r_wen;
  logic [WIDTH-1:0]   r_waddr;
  logic [WIDTH-1:0]   r_wdata;
  logic               r_coreHold;
  logic               r_done;
  logic               r_error;

  logic               w_ready;
  logic               w_accept;
  logic               w_fieldDone;
  logic [WIDTH-1:0]   w_word;
  logic               w_lastWord;

  // The top byte of a field is never stored; it is merged straight from the bus.
  assign w_word      = {bus.in_data, r_asm};
  assign w_ready     = (r_state == HEADER) || (r_state == LOAD);
  assign w_accept    = bus.in_valid && w_ready;
  assign w_fieldDone = w_accept && (r_byteCnt == 2'd3);
  assign w_lastWord  = ({{(WIDTH-IDXW){1'b0}}, r_wordIdx} == (r_n - WIDTH'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= HEADER;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      HEADER: begin
        if (w_fieldDone) begin
          if (w_word == '0) begin
            w_nextState = FINISH;
          end else if (w_word > WIDTH'(ROMDEPTH)) begin
            w_nextState = ERROR;
          end else begin
            w_nextState = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_fieldDone && w_lastWord) begin
          w_nextState = FINISH;
        end
      end
      FINISH:  w_nextState = DONE;
      DONE:    w_nextState = DONE;
      ERROR:   w_nextState = ERROR;
      default: w_nextState = HEADER;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_byteCnt  <= '0;
      r_asm      <= '0;
      r_n        <= '0;
      r_wordIdx  <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_coreHold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      if (w_accept) begin
        r_byteCnt <= r_byteCnt + 2'd1;
        case (r_byteCnt)
          2'd0:    r_asm[7:0]   <= bus.in_data;
          2'd1:    r_asm[15:8]  <= bus.in_data;
          2'd2:    r_asm[23:16] <= bus.in_data;
          default: r_asm        <= r_asm;
        endcase
      end
      if ((r_state == HEADER) && w_fieldDone) begin
        r_n <= w_word;
      end
      if ((r_state == LOAD) && w_fieldDone) begin
        r_wen     <= 1'b1;
        r_waddr   <= {{(WIDTH-IDXW-2){1'b0}}, r_wordIdx, 2'b00};
        r_wdata   <= w_word;
        r_wordIdx <= r_wordIdx + IDXW'(1);
      end
      // FINISH exists so the last write strobe completes before the core is released.
      if (r_state == FINISH) begin
        r_done     <= 1'b1;
        r_coreHold <= 1'b0;
      end
      if ((r_state == HEADER) && (w_nextState == ERROR)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wen      = r_wen;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;
  assign core_hold    = r_coreHold;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a byte-counting reference model predicts every
// output each cycle, plus fixed-value checks on the directed images.
module tb_prog_loader;

  localparam int ROMDEPTH = 2048;

  logic clock;
  logic reset;
  logic core_hold;
  logic done;
  logic error;

  prog_loader_if #(.WIDTH(32)) bif ();

  prog_loader #(.WIDTH(32), .ROMDEPTH(ROMDEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bif.slave),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: expected outputs after the most recent edge.
  logic        mValid = 1'b0;
  logic        mReady, mDone, mError, mHold, mWen, mHaveN, mFinishPending;
  logic [31:0] mAddr, mData, mField, mN;
  int          mBytes, mIdx;

  logic [31:0] tbMem [0:ROMDEPTH-1];
  int          wenCount;
  logic [31:0] lastAddr, lastData;
  logic [31:0] img [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // The model counts accepted bytes and words rather than tracking a state machine.
  task automatic modelStep();
    if (reset) begin
      mValid = 1'b1; mReady = 1'b1; mDone = 1'b0; mError = 1'b0; mHold = 1'b1;
      mWen = 1'b0; mAddr = '0; mData = '0; mField = '0; mN = '0;
      mBytes = 0; mIdx = 0; mHaveN = 1'b0; mFinishPending = 1'b0;
    end else if (mValid) begin
      mWen = 1'b0;
      if (mFinishPending) begin
        mDone = 1'b1; mHold = 1'b0; mFinishPending = 1'b0;
      end
      if (bif.in_valid && mReady) begin
        mField = {bif.in_data, mField[31:8]};
        mBytes++;
        if (mBytes == 4) begin
          mBytes = 0;
          if (!mHaveN) begin
            mHaveN = 1'b1;
            mN = mField;
            if (mN == 0) begin
              mReady = 1'b0; mFinishPending = 1'b1;
            end else if (mN > ROMDEPTH) begin
              mReady = 1'b0; mError = 1'b1;
            end
          end else begin
            mWen = 1'b1; mAddr = 32'(mIdx * 4); mData = mField; mIdx++;
            if (mN == 32'(mIdx)) begin
              mReady = 1'b0; mFinishPending = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic compareStep();
    checkOutput("in_ready",  {31'b0, bif.in_ready}, {31'b0, mReady});
    checkOutput("wen",       {31'b0, bif.wen},      {31'b0, mWen});
    checkOutput("waddr",     bif.waddr,             mAddr);
    checkOutput("wdata",     bif.wdata,             mData);
    checkOutput("done",      {31'b0, done},         {31'b0, mDone});
    checkOutput("error",     {31'b0, error},        {31'b0, mError});
    checkOutput("core_hold", {31'b0, core_hold},    {31'b0, mHold});
    if (bif.wen === 1'b1) begin
      tbMem[bif.waddr[12:2]] = bif.wdata;
      wenCount++;
      lastAddr = bif.waddr;
      lastData = bif.wdata;
    end
  endtask

  initial forever begin
    @(posedge clock);
    modelStep();
  end

  initial forever begin
    @(negedge clock);
    if (mValid) compareStep();
  end

  task automatic doReset();
    bif.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    wenCount = 0;
  endtask

  // Presents one byte after a random idle gap and holds it until it is taken.
  task automatic applyStimulus(input logic [7:0] b, input int maxGap);
    logic acc;
    int gap;
    acc = 1'b0;
    gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
    for (int g = 0; g < gap; g++) begin
      bif.in_valid = 1'b0;
      bif.in_data  = 8'($urandom);
      @(posedge clock); #1;
    end
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    for (int t = 0; t < 20; t++) begin
      acc = bif.in_ready;
      @(posedge clock); #1;
      if (acc) break;
    end
    if (!acc) checkOutput("byteAcceptTimeout", 32'd0, 32'd1);
    bif.in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    logic [31:0] tmp;
    tmp = w;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(tmp[7:0], maxGap);
      tmp = tmp >> 8;
    end
  endtask

  task automatic sendImage(input int maxGap);
    sendWord(32'(img.size()), maxGap);
    foreach (img[i]) sendWord(img[i], maxGap);
  endtask

  task automatic waitDone(input int maxCycles);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < maxCycles; t++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    checkOutput("doneTimeout", {31'b0, seen}, 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    int bad;
    int n;
    reset = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    wenCount = 0;
    lastAddr = '0;
    lastData = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("resetHold",  {31'b0, core_hold},    32'd1);
    checkOutput("resetReady", {31'b0, bif.in_ready}, 32'd1);
    checkOutput("resetDone",  {31'b0, done},         32'd0);

    $display("[TB] two-word image, no gaps");
    img = {32'h0000_0013, 32'h0010_0093};
    sendImage(0);
    waitDone(10);
    checkOutput("t1WenCount", 32'(wenCount), 32'd2);
    checkOutput("t1Mem0", tbMem[0], 32'h0000_0013);
    checkOutput("t1Mem1", tbMem[1], 32'h0010_0093);
    checkOutput("t1Hold", {31'b0, core_hold}, 32'd0);

    $display("[TB] empty image");
    doReset();
    sendWord(32'd0, 0);
    @(posedge clock); #1;
    checkOutput("t2Done",     {31'b0, done},         32'd1);
    checkOutput("t2Ready",    {31'b0, bif.in_ready}, 32'd0);
    checkOutput("t2WenCount", 32'(wenCount),         32'd0);

    $display("[TB] oversize headers");
    doReset();
    sendWord(32'd2049, 0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("t3Error",    {31'b0, error},        32'd1);
    checkOutput("t3Done",     {31'b0, done},         32'd0);
    checkOutput("t3Hold",     {31'b0, core_hold},    32'd1);
    checkOutput("t3Ready",    {31'b0, bif.in_ready}, 32'd0);
    checkOutput("t3WenCount", 32'(wenCount),         32'd0);
    doReset();
    sendWord(32'h8000_0001, 0);
    @(posedge clock); #1;
    checkOutput("t3bError", {31'b0, error}, 32'd1);

    $display("[TB] three words with random gaps");
    doReset();
    img = {};
    for (int i = 0; i < 3; i++) img.push_back($urandom);
    sendImage(5);
    waitDone(10);
    checkOutput("t4WenCount", 32'(wenCount), 32'd3);

    $display("[TB] random images");
    for (int r = 0; r < 4; r++) begin
      doReset();
      img = {};
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) img.push_back($urandom);
      sendImage(3);
      waitDone(10);
      checkOutput("randWenCount", 32'(wenCount), 32'(n));
    end

    $display("[TB] reset mid-stream then resend");
    doReset();
    img = {32'hDEAD_BEEF, 32'h1234_5678};
    sendWord(32'd2, 0);
    sendWord(img[0], 0);
    applyStimulus(8'h78, 0);
    applyStimulus(8'h56, 0);
    doReset();
    sendImage(2);
    waitDone(10);
    checkOutput("t6WenCount", 32'(wenCount), 32'd2);
    checkOutput("t6Mem0", tbMem[0], 32'hDEAD_BEEF);
    checkOutput("t6Mem1", tbMem[1], 32'h1234_5678);

    $display("[TB] full-depth image");
    doReset();
    img = {};
    for (int i = 0; i < ROMDEPTH; i++) img.push_back(32'(i));
    sendImage(0);
    waitDone(10);
    checkOutput("t5LastAddr", lastAddr,      32'h0000_1FFC);
    checkOutput("t5LastData", lastData,      32'h0000_07FF);
    checkOutput("t5WenCount", 32'(wenCount), 32'(ROMDEPTH));
    bad = 0;
    for (int i = 0; i < ROMDEPTH; i++) if (tbMem[i] !== 32'(i)) bad++;
    checkOutput("t5Readback", 32'(bad), 32'd0);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
